// File: rtl/readout_rx_seq_ctrl.sv
// Readout RX instruction sequencer: fetches from a synchronous-read instruction memory,
// decodes NOP/WAIT/MEAS/LOOP/JUMP/HALT and drives the PC register load interface.
module readout_rx_seq_ctrl #(
   parameter int unsigned PC_WIDTH   = 11,
   parameter int unsigned INST_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [PC_WIDTH-1:0]   start_pc,
   input  logic                  abort,
   input  logic [PC_WIDTH-1:0]   PC,
   input  logic [INST_WIDTH-1:0] inst_rdata,
   output logic                  update_pc,
   output logic [PC_WIDTH-1:0]   next_PC,
   output logic                  meas_valid,
   input  logic                  meas_ready,
   output logic [7:0]            meas_tag,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_WAIT,
      S_MEAS,
      S_DONE
   } state_e;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_WAIT = 4'd1,
      OP_MEAS = 4'd2,
      OP_LOOP = 4'd3,
      OP_JUMP = 4'd4,
      OP_HALT = 4'd5
   } opcode_e;

   state_e              state_q, state_d;
   logic [15:0]         wcnt_q, wcnt_d;
   logic [15:0]         loop_cnt_q, loop_cnt_d;
   logic                loop_active_q, loop_active_d;
   logic                meas_valid_q, meas_valid_d;
   logic [7:0]          meas_tag_q, meas_tag_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;

   logic [3:0]          opcode;
   logic [PC_WIDTH-1:0] target;
   logic [15:0]         imm;
   logic [PC_WIDTH-1:0] pc_inc;
   logic                loop_take;
   logic                unused_inst;

   assign opcode      = inst_rdata[31:28];
   assign target      = inst_rdata[16+PC_WIDTH-1:16];
   assign imm         = inst_rdata[15:0];
   assign pc_inc      = PC + PC_WIDTH'(1);
   assign unused_inst = ^inst_rdata;

   // A fresh LOOP jumps when imm is non-zero; an armed LOOP jumps while the shared count remains.
   assign loop_take = loop_active_q ? (loop_cnt_q != '0) : (imm != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wcnt_q        <= '0;
         loop_cnt_q    <= '0;
         loop_active_q <= 1'b0;
         meas_valid_q  <= 1'b0;
         meas_tag_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         wcnt_q        <= wcnt_d;
         loop_cnt_q    <= loop_cnt_d;
         loop_active_q <= loop_active_d;
         meas_valid_q  <= meas_valid_d;
         meas_tag_q    <= meas_tag_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wcnt_d        = wcnt_q;
      loop_cnt_d    = loop_cnt_q;
      loop_active_d = loop_active_q;
      meas_valid_d  = meas_valid_q;
      meas_tag_d    = meas_tag_q;
      error_d       = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               loop_active_d = 1'b0;
               state_d       = S_FETCH;
            end
         end
         S_FETCH: state_d = S_EXEC;
         S_EXEC: begin
            case (opcode)
               OP_NOP:  state_d = S_FETCH;
               OP_WAIT: begin
                  if (imm == '0) begin
                     state_d = S_FETCH;
                  end else begin
                     wcnt_d  = imm - 16'd1;
                     state_d = S_WAIT;
                  end
               end
               OP_MEAS: begin
                  meas_valid_d = 1'b1;
                  meas_tag_d   = imm[7:0];
                  state_d      = S_MEAS;
               end
               OP_LOOP: begin
                  state_d = S_FETCH;
                  if (!loop_active_q) begin
                     if (imm != '0) begin
                        loop_cnt_d    = imm - 16'd1;
                        loop_active_d = 1'b1;
                     end
                  end else if (loop_cnt_q == '0) begin
                     loop_active_d = 1'b0;
                  end else begin
                     loop_cnt_d = loop_cnt_q - 16'd1;
                  end
               end
               OP_JUMP: state_d = S_FETCH;
               OP_HALT: state_d = S_DONE;
               default: begin
                  error_d = 1'b1;
                  state_d = S_DONE;
               end
            endcase
         end
         S_WAIT: begin
            if (wcnt_q == '0) begin
               state_d = S_FETCH;
            end else begin
               wcnt_d = wcnt_q - 16'd1;
            end
         end
         S_MEAS: begin
            if (meas_ready) begin
               meas_valid_d = 1'b0;
               state_d      = S_FETCH;
            end
         end
         S_DONE: begin
            if (start) begin
               error_d       = 1'b0;
               loop_active_d = 1'b0;
               state_d       = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Abort discards every decision above, including a tag captured in the same cycle.
      if (abort) begin
         state_d       = S_IDLE;
         meas_valid_d  = 1'b0;
         meas_tag_d    = meas_tag_q;
         loop_active_d = 1'b0;
         error_d       = 1'b0;
      end
      busy_d = (state_d == S_FETCH) || (state_d == S_EXEC) ||
               (state_d == S_WAIT)  || (state_d == S_MEAS);
      done_d = (state_d == S_DONE);
   end

   always_comb begin
      update_pc = 1'b0;
      next_PC   = '0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               update_pc = 1'b1;
               next_PC   = start_pc;
            end
         end
         S_EXEC: begin
            case (opcode)
               OP_NOP: begin
                  update_pc = 1'b1;
                  next_PC   = pc_inc;
               end
               OP_WAIT: begin
                  if (imm == '0) begin
                     update_pc = 1'b1;
                     next_PC   = pc_inc;
                  end
               end
               OP_LOOP: begin
                  update_pc = 1'b1;
                  next_PC   = loop_take ? target : pc_inc;
               end
               OP_JUMP: begin
                  update_pc = 1'b1;
                  next_PC   = target;
               end
               default: ;
            endcase
         end
         S_WAIT: begin
            if (wcnt_q == '0) begin
               update_pc = 1'b1;
               next_PC   = pc_inc;
            end
         end
         S_MEAS: begin
            if (meas_ready) begin
               update_pc = 1'b1;
               next_PC   = pc_inc;
            end
         end
         default: ;
      endcase
      if (abort) begin
         update_pc = 1'b0;
         next_PC   = '0;
      end
   end

   assign meas_valid = meas_valid_q;
   assign meas_tag   = meas_tag_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule
